// File: rtl/fml_arbiter4.sv
// fml_arbiter4: four-master FML 4x32 burst arbiter in front of the DDR
// controller. One burst is granted at a time. The write data/byte-select path
// stays steered to the granted master for all four write beats. Read data is
// broadcast to every master, and each master qualifies it with its own ack.
// Build option: define FMLARB_FIXEDPRIO_EN for fixed priority (master 0
// highest). Otherwise masters are served round-robin.
module fml_arbiter4 #(
  parameter int sdram_depth = 26
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [4*sdram_depth-1:0]   m_adr,
  input  logic [3:0]                 m_stb,
  input  logic [3:0]                 m_we,
  output logic [3:0]                 m_ack,
  input  logic [15:0]                m_sel,
  input  logic [127:0]               m_di,
  output logic [31:0]                m_do,
  output logic [sdram_depth-1:0]     fml_adr,
  output logic                       fml_stb,
  output logic                       fml_we,
  input  logic                       fml_ack,
  output logic [3:0]                 fml_sel,
  output logic [31:0]                fml_di,
  input  logic [31:0]                fml_do,
  output logic [1:0]                 arb_grant,
  output logic                       arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WBURST = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [1:0]             beat_q, beat_d;
  logic [sdram_depth-1:0] adr_q, adr_d;
  logic                   we_q, we_d;
`ifndef FMLARB_FIXEDPRIO_EN
  logic [1:0]             last_q, last_d;
`endif

  logic [sdram_depth-1:0] g_adr_s;
  logic                   g_stb_s;
  logic                   g_we_s;
  logic [3:0]             g_sel_s;
  logic [31:0]            g_di_s;
  logic [1:0]             pick_s;
  logic                   in_req_s;
  logic                   wr_path_s;

  // Select the fields of the currently granted master.
  always_comb begin
    g_adr_s = '0;
    g_sel_s = 4'h0;
    g_di_s  = 32'h0;
    case (grant_q)
      2'd0: begin g_adr_s = m_adr[0*sdram_depth +: sdram_depth]; g_sel_s = m_sel[3:0];   g_di_s = m_di[31:0];   end
      2'd1: begin g_adr_s = m_adr[1*sdram_depth +: sdram_depth]; g_sel_s = m_sel[7:4];   g_di_s = m_di[63:32];  end
      2'd2: begin g_adr_s = m_adr[2*sdram_depth +: sdram_depth]; g_sel_s = m_sel[11:8];  g_di_s = m_di[95:64];  end
      2'd3: begin g_adr_s = m_adr[3*sdram_depth +: sdram_depth]; g_sel_s = m_sel[15:12]; g_di_s = m_di[127:96]; end
      default: begin g_adr_s = '0; g_sel_s = 4'h0; g_di_s = 32'h0; end
    endcase
    g_stb_s = m_stb[grant_q];
    g_we_s  = m_we[grant_q];
  end

`ifdef FMLARB_FIXEDPRIO_EN
  // Fixed priority: lowest-numbered requesting master wins.
  always_comb begin
    casez (m_stb)
      4'b???1: pick_s = 2'd0;
      4'b??10: pick_s = 2'd1;
      4'b?100: pick_s = 2'd2;
      4'b1000: pick_s = 2'd3;
      default: pick_s = 2'd0;
    endcase
  end
`else
  // Round-robin: search starts just after the master that was acked last.
  always_comb begin : rr_pick
    logic [1:0] idx;
    logic       found;
    pick_s = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && m_stb[idx]) begin
        pick_s = idx;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
  end
`endif

  // Next-state logic: grant, wait for ack, then run out the write beats.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    adr_d   = adr_q;
    we_d    = we_q;
`ifndef FMLARB_FIXEDPRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|m_stb) begin
          state_d = ST_REQ;
          grant_d = pick_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Remember what was presented so the bus holds it once REQ ends.
        adr_d = g_adr_s;
        we_d  = g_we_s;
        if (fml_ack) begin
`ifndef FMLARB_FIXEDPRIO_EN
          last_d = grant_q;
`endif
          if (g_we_s) begin
            state_d = ST_WBURST;
            beat_d  = 2'd2;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!g_stb_s) begin
          // Master withdrew before the ack: abandon without touching last.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WBURST: begin
        if (beat_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd0;
      beat_q  <= 2'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
`ifndef FMLARB_FIXEDPRIO_EN
      last_q  <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
`ifndef FMLARB_FIXEDPRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // Output steering, combinational from the registered state and grant.
  always_comb begin
    in_req_s  = (state_q == ST_REQ);
    wr_path_s = (in_req_s && fml_ack && g_we_s) || (state_q == ST_WBURST);
    fml_stb   = in_req_s && g_stb_s;
    fml_adr   = in_req_s ? g_adr_s : adr_q;
    fml_we    = in_req_s ? g_we_s  : we_q;
    fml_sel   = wr_path_s ? g_sel_s : 4'h0;
    fml_di    = wr_path_s ? g_di_s  : 32'h0;
    m_ack     = (in_req_s && fml_ack) ? (4'b0001 << grant_q) : 4'b0000;
    m_do      = fml_do;
    arb_grant = grant_q;
    arb_busy  = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_fml_arbiter4.sv
// Self-checking bench for fml_arbiter4: directed scenarios plus randomized
// masters and a reactive controller, all compared against a burst-level model.
module tb_fml_arbiter4;
  localparam int D = 26;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic [4*D-1:0] m_adr = '0;
  logic [3:0]     m_stb = 4'h0;
  logic [3:0]     m_we = 4'h0;
  logic [3:0]     m_ack;
  logic [15:0]    m_sel = 16'h0;
  logic [127:0]   m_di = '0;
  logic [31:0]    m_do;
  logic [D-1:0]   fml_adr;
  logic           fml_stb;
  logic           fml_we;
  logic           fml_ack = 1'b0;
  logic [3:0]     fml_sel;
  logic [31:0]    fml_di;
  logic [31:0]    fml_do = 32'h0;
  logic [1:0]     arb_grant;
  logic           arb_busy;

  fml_arbiter4 #(.sdram_depth(D)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we), .m_ack(m_ack),
    .m_sel(m_sel), .m_di(m_di), .m_do(m_do),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack),
    .fml_sel(fml_sel), .fml_di(fml_di), .fml_do(fml_do),
    .arb_grant(arb_grant), .arb_busy(arb_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Burst-level model: phase 0 = nobody granted, 1 = granted awaiting ack,
  // 2 = remaining write data beats after the ack.
  int           md_phase = 0;
  int           md_grant = 0;
  int           md_last = 3;
  int           md_wleft = 0;
  logic [D-1:0] md_hadr = '0;
  logic         md_hwe = 1'b0;
  int           ack_cnt = 0;
  int           ack_delay = 0;

  logic [3:0]   ack_log[$];
  logic [31:0]  di_log[$];
  logic [3:0]   sel_log[$];
  logic [D-1:0] adr_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] adr_of(input int i);
    return m_adr[i*D +: D];
  endfunction

  function automatic int pick();
    int p;
    p = 0;
`ifdef FMLARB_FIXEDPRIO_EN
    for (int i = 3; i >= 0; i--) if (m_stb[i]) p = i;
`else
    for (int k = 4; k >= 1; k--) if (m_stb[(md_last + k) % 4]) p = (md_last + k) % 4;
`endif
    return p;
  endfunction

  task automatic model_reset();
    md_phase = 0; md_grant = 0; md_last = 3; md_wleft = 0;
    md_hadr = '0; md_hwe = 1'b0; ack_cnt = 0;
  endtask

  task automatic model_step();
    int g;
    g = md_grant;
    if (!sys_rst_n) begin
      model_reset();
    end else begin
      if (md_phase == 1 && m_stb[g] && !fml_ack) ack_cnt++;
      else ack_cnt = 0;
      case (md_phase)
        0: if (m_stb != 4'h0) begin md_grant = pick(); md_phase = 1; end
        1: begin
          md_hadr = adr_of(g);
          md_hwe  = m_we[g];
          if (fml_ack) begin
            md_last = g;
            if (m_we[g]) begin md_phase = 2; md_wleft = 3; end
            else md_phase = 0;
          end else if (!m_stb[g]) begin
            md_phase = 0;
          end
        end
        2: begin md_wleft--; if (md_wleft == 0) md_phase = 0; end
        default: md_phase = 0;
      endcase
    end
  endtask

  // Controller stand-in: ack once the granted strobe has been high ack_delay cycles.
  task automatic drive_ack();
    fml_ack = (md_phase == 1) && m_stb[md_grant] && (ack_cnt >= ack_delay);
  endtask

  task automatic sample();
    if (m_ack != 4'h0) ack_log.push_back(m_ack);
    if (fml_sel != 4'h0) begin di_log.push_back(fml_di); sel_log.push_back(fml_sel); end
    if (fml_stb) adr_log.push_back(fml_adr);
  endtask

  task automatic clear_logs();
    ack_log.delete(); di_log.delete(); sel_log.delete(); adr_log.delete();
  endtask

  task automatic tick();
    #2;
    sample();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge sys_clk) begin : compare
    int  g;
    bit  inreq, wr;
    logic [3:0]  e_sel;
    logic [31:0] e_di;
    g     = md_grant;
    inreq = (md_phase == 1);
    wr    = (inreq && fml_ack && m_we[g]) || (md_phase == 2);
    e_sel = wr ? m_sel[g*4 +: 4] : 4'h0;
    e_di  = wr ? m_di[g*32 +: 32] : 32'h0;
    chk("fml_stb", fml_stb, inreq && m_stb[g]);
    chk("fml_adr", fml_adr, inreq ? adr_of(g) : md_hadr);
    chk("fml_we", fml_we, inreq ? m_we[g] : md_hwe);
    chk("m_ack", m_ack, (inreq && fml_ack) ? (4'b0001 << g) : 4'b0000);
    chk("fml_sel", fml_sel, e_sel);
    chk("fml_di", fml_di, e_di);
    chk("arb_busy", arb_busy, md_phase != 0);
    chk("arb_grant", arb_grant, g[1:0]);
    chk("m_do", m_do, fml_do);
  end

  initial begin : stim
    bit          was;
    bit          seen;
    int          b;
    logic [3:0]  jack;
    logic [3:0]  exp_ack;
    model_reset();
    repeat (3) tick();
    sys_rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin drive_ack(); tick(); end
    chk("idle_stb", fml_stb, 1'b0);
    chk("idle_ack", m_ack, 4'h0);
    chk("idle_busy", arb_busy, 1'b0);
    chk("idle_grant", arb_grant, 2'd0);
    chk("idle_adr", fml_adr, 26'h0);
    chk("idle_sel", fml_sel, 4'h0);

    // Master 3 abandons before ack; master 0 must win next.
    clear_logs();
    m_adr[3*D +: D] = 26'h3ABCDE0;
    m_stb = 4'b1000; ack_delay = 100;
    drive_ack(); tick();
    chk("abn_grant", arb_grant, 2'd3);
    chk("abn_busy", arb_busy, 1'b1);
    chk("abn_stb", fml_stb, 1'b1);
    drive_ack(); tick();
    m_stb = 4'b0000;
    drive_ack(); tick();
    chk("abn_idle", arb_busy, 1'b0);
    chk("abn_noack", ack_log.size(), 0);

    // All four masters read continuously.
    clear_logs();
    m_stb = 4'b1111; ack_delay = 1;
    drive_ack(); tick();
    chk("rr_first", arb_grant, 2'd0);
    for (int i = 0; i < 40; i++) begin drive_ack(); tick(); end
    m_stb = 4'b0000;
    drive_ack(); tick(); drive_ack(); tick();
    chk("rr_count", ack_log.size() >= 8, 1'b1);
    for (int k = 0; k < 8 && k < ack_log.size(); k++) begin
`ifdef FMLARB_FIXEDPRIO_EN
      exp_ack = 4'b0001;
`else
      exp_ack = 4'b0001 << (k % 4);
`endif
      chk("rr_order", ack_log[k], exp_ack);
    end

    // Single read from master 2, ack three cycles after strobe.
    clear_logs();
    m_adr[2*D +: D] = 26'h0123450; m_we = 4'h0; m_stb = 4'b0100; ack_delay = 3;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (seen) m_stb[2] = 1'b0;
      drive_ack(); was = fml_ack; tick();
      if (was) seen = 1'b1;
    end
    chk("rd_acks", ack_log.size(), 1);
    if (ack_log.size() > 0) chk("rd_ackval", ack_log[0], 4'b0100);
    chk("rd_stbcycles", adr_log.size(), 4);
    for (int k = 0; k < adr_log.size(); k++) chk("rd_adr", adr_log[k], 26'h0123450);
    chk("rd_sel", sel_log.size(), 0);

    // Write burst from master 1.
    clear_logs();
    m_adr[1*D +: D] = 26'h0000A40; m_we = 4'b0010; m_sel[7:4] = 4'hF; m_stb = 4'b0010;
    ack_delay = 1; b = 0;
    for (int i = 0; i < 14; i++) begin
      if (b > 0) m_stb[1] = 1'b0;
      m_di[63:32] = 32'hA0 + 32'(b);
      drive_ack(); was = fml_ack; tick();
      if ((was || b > 0) && b < 8) b++;
    end
    chk("wr_beats", di_log.size(), 4);
    for (int k = 0; k < 4 && k < di_log.size(); k++) begin
      chk("wr_di", di_log[k], 32'hA0 + 32'(k));
      chk("wr_sel", sel_log[k], 4'hF);
    end

    // Reset pulsed during write beat 2.
    m_di[63:32] = 32'hB0; m_stb = 4'b0010; ack_delay = 0;
    for (int i = 0; i < 10; i++) begin
      drive_ack(); was = fml_ack; tick();
      if (was) break;
    end
    m_stb = 4'h0;
    #2;
    chk("rst_pre_sel", fml_sel, 4'hF);
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_sel", fml_sel, 4'h0);
    chk("rst_di", fml_di, 32'h0);
    chk("rst_stb", fml_stb, 1'b0);
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_grant", arb_grant, 2'd0);
    fml_ack = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
    clear_logs();
    m_we = 4'h0; m_stb = 4'b0001; ack_delay = 2; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (seen) m_stb[0] = 1'b0;
      drive_ack(); was = fml_ack; tick();
      if (was) seen = 1'b1;
    end
    chk("post_rst_acks", ack_log.size(), 1);
    if (ack_log.size() > 0) chk("post_rst_ack", ack_log[0], 4'b0001);

    // Randomized masters and controller.
    jack = 4'h0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!m_stb[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            m_stb[i] = 1'b1;
            m_we[i]  = $urandom_range(0, 1) == 1;
            m_adr[i*D +: D] = D'($urandom);
          end
        end else if (jack[i]) begin
          m_stb[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          m_stb[i] = 1'b0;
        end
        m_sel[i*4 +: 4] = 4'($urandom);
        m_di[i*32 +: 32] = $urandom;
      end
      fml_do = $urandom;
      if (ack_cnt == 0) ack_delay = $urandom_range(0, 3);
      drive_ack();
      jack = (md_phase == 1 && fml_ack) ? (4'b0001 << md_grant) : 4'h0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
